// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared types for the reset sequencer: the sequencing FSM state and the
//   encoding of the reset cause reported on cause_o.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_SW  = 2'b01,
        CAUSE_WDT = 2'b10
    } cause_e;

endpackage

// File: rtl/reset_seq_wdt.sv
// reset_seq_wdt
//   Watchdog for the reset sequencer. Counts cycles spent in RUN while
//   enabled and flags expiry when the count reaches timeout_i-1 without a
//   kick in the same cycle.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   run_i      sequencer is in RUN
//   clr_i      sequencer is restarting this cycle (software request)
//   en_i       watchdog enable
//   kick_i     restart strobe
//   timeout_i  period in cycles, 0 disables
//   expire_o   expiry this cycle (combinational from the registered count)
module reset_seq_wdt #(
    parameter int WDT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             kick_i,
    input  logic [WDT_W-1:0] timeout_i,
    output logic             expire_o
);

    localparam logic [WDT_W-1:0] ONE = WDT_W'(1);

    logic [WDT_W-1:0] cnt_q, cnt_d;
    logic             active;

    assign active = run_i & en_i & (timeout_i != '0);

    // >= rather than == so that lowering the timeout below the current
    // count expires on the very next edge instead of wrapping around.
    assign expire_o = active & ~kick_i & (cnt_q >= (timeout_i - ONE));

    always_comb begin
        cnt_d = cnt_q + ONE;
        if (!active || kick_i || clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reset_seq.sv
// reset_seq
//   Reset sequencer: holds all domains in reset for HOLD_CYCLES, then
//   releases them one at a time STAGGER_CYCLES apart. A software request or
//   a watchdog expiry restarts the whole sequence.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high power-on reset
//   sw_rst_req_i   software reset request (level, sampled every cycle)
//   wdt_en_i       watchdog enable
//   wdt_kick_i     watchdog restart strobe
//   wdt_timeout_i  watchdog period in cycles, 0 disables
//   rst_on         per-domain active-low resets
//   busy_o         high while any domain is held in reset
//   cause_o        cause of the most recent reset (00 POR, 01 SW, 10 WDT)
//   wdt_bite_o     one-cycle pulse when the watchdog forces a reset
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int N_DOMAINS      = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int WDT_W          = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sw_rst_req_i,
    input  logic                 wdt_en_i,
    input  logic                 wdt_kick_i,
    input  logic [WDT_W-1:0]     wdt_timeout_i,
    output logic [N_DOMAINS-1:0] rst_on,
    output logic                 busy_o,
    output logic [1:0]           cause_o,
    output logic                 wdt_bite_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DOM_W   = 4;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [DOM_W-1:0] LAST_DOM  = DOM_W'(N_DOMAINS - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DOM_W-1:0]       dom_q, dom_d;     // next domain to release
    logic [N_DOMAINS-1:0]   rst_n_q, rst_n_d;
    logic                   busy_q, busy_d;
    cause_e                 cause_q, cause_d;
    logic                   bite_q, bite_d;

    logic                   wdt_expire;
    logic                   wdt_fire;
    logic                   restart;
    logic                   cnt_done;

    reset_seq_wdt #(
        .WDT_W (WDT_W)
    ) u_wdt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .run_i     (state_q == ST_RUN),
        .clr_i     (sw_rst_req_i),
        .en_i      (wdt_en_i),
        .kick_i    (wdt_kick_i),
        .timeout_i (wdt_timeout_i),
        .expire_o  (wdt_expire)
    );

    // Software request beats a simultaneous watchdog expiry.
    assign wdt_fire = wdt_expire & ~sw_rst_req_i;
    assign restart  = sw_rst_req_i | wdt_fire;

    assign cnt_done = (state_q == ST_HOLD) ? (cnt_q == HOLD_LAST) : (cnt_q == STAG_LAST);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            dom_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        if (restart) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            dom_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_done) begin
                        cnt_d   = '0;
                        dom_d   = DOM_W'(1);
                        // A single domain finishes the sequence on its own release.
                        state_d = (N_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_done) begin
                        cnt_d = '0;
                        if (dom_q == LAST_DOM) begin
                            state_d = ST_RUN;
                        end else begin
                            dom_d = dom_q + DOM_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Output logic (feeds the output registers so every output is a flop)
    always_comb begin
        rst_n_d = rst_n_q;
        cause_d = cause_q;
        bite_d  = 1'b0;
        busy_d  = (state_d != ST_RUN);
        if (sw_rst_req_i) begin
            rst_n_d = '0;
            cause_d = CAUSE_SW;
        end else if (wdt_fire) begin
            rst_n_d = '0;
            cause_d = CAUSE_WDT;
            bite_d  = 1'b1;
        end else if (cnt_done && state_q == ST_HOLD) begin
            rst_n_d[0] = 1'b1;
        end else if (cnt_done && state_q == ST_RELEASE) begin
            for (int k = 0; k < N_DOMAINS; k++) begin
                if (dom_q == DOM_W'(k)) begin
                    rst_n_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_POR;
            bite_q  <= 1'b0;
        end else begin
            rst_n_q <= rst_n_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
            bite_q  <= bite_d;
        end
    end

    assign rst_on     = rst_n_q;
    assign busy_o     = busy_q;
    assign cause_o    = cause_q;
    assign wdt_bite_o = bite_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq
//   Directed bench for reset_seq (3 domains, hold 16, stagger 8). Each cycle
//   a timing model of the release schedule and watchdog pushes the expected
//   outputs onto a queue; after the edge they are popped and compared.
//   Scenario milestones are additionally checked against fixed constants.
module tb_reset_seq;

    localparam int N  = 3;
    localparam int H  = 16;
    localparam int S  = 8;
    localparam int WW = 16;
    localparam int RUN_AT = H + (N - 1) * S;

    typedef struct {
        logic [2:0] rn;
        logic       busy;
        logic [1:0] cause;
        logic       bite;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sw = 1'b0;
    logic          en = 1'b0;
    logic          kick = 1'b0;
    logic [WW-1:0] to = '0;
    logic [N-1:0]  rst_on;
    logic          busy;
    logic [1:0]    cause;
    logic          bite;

    int   total = 0;
    int   bad   = 0;
    int   edge_no = 0;
    exp_t q[$];

    // model state
    int         m_rel   = 0;
    int         m_wcnt  = 0;
    logic [1:0] m_cause = 2'b00;
    logic       m_bite  = 1'b0;

    always #5 clk = ~clk;

    reset_seq #(
        .N_DOMAINS      (N),
        .HOLD_CYCLES    (H),
        .STAGGER_CYCLES (S),
        .WDT_W          (WW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sw_rst_req_i  (sw),
        .wdt_en_i      (en),
        .wdt_kick_i    (kick),
        .wdt_timeout_i (to),
        .rst_on        (rst_on),
        .busy_o        (busy),
        .cause_o       (cause),
        .wdt_bite_o    (bite)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @edge %0d: got %0h want %0h", tag, edge_no, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        exp_t e;
        logic run_now, active, expire;
        run_now = (m_rel >= RUN_AT);
        active  = run_now && en && (to != 0);
        expire  = active && !kick && (m_wcnt >= int'(to) - 1);
        if (rst) begin
            m_rel = 0; m_cause = 2'b00; m_bite = 1'b0; m_wcnt = 0;
        end else if (sw) begin
            m_rel = 0; m_cause = 2'b01; m_bite = 1'b0; m_wcnt = 0;
        end else if (expire) begin
            m_rel = 0; m_cause = 2'b10; m_bite = 1'b1; m_wcnt = 0;
        end else begin
            if (m_rel < 1000000) m_rel++;
            m_bite = 1'b0;
            m_wcnt = (active && !kick) ? m_wcnt + 1 : 0;
        end
        for (int d = 0; d < N; d++) e.rn[d] = (m_rel >= H + d * S);
        e.busy  = (m_rel < RUN_AT);
        e.cause = m_cause;
        e.bite  = m_bite;
        q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        edge_no++;
        e = q.pop_front();
        chk("rst_on", {1'b0, rst_on}, {1'b0, e.rn});
        chk("busy",   {3'b0, busy},   {3'b0, e.busy});
        chk("cause",  {2'b0, cause},  {2'b0, e.cause});
        chk("bite",   {3'b0, bite},   {3'b0, e.bite});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Power-on reset
        rst = 1'b1;
        run(5);
        chk("por_hold_rst_on", {1'b0, rst_on}, 4'h0);
        chk("por_hold_busy", {3'b0, busy}, 4'h1);
        chk("por_hold_cause", {2'b0, cause}, 4'h0);

        // Release schedule after POR
        rst = 1'b0;
        for (int e = 1; e <= RUN_AT + 4; e++) begin
            cycle();
            if (e == 15) chk("por_e15", {1'b0, rst_on}, 4'b0000);
            if (e == 16) chk("por_e16", {1'b0, rst_on}, 4'b0001);
            if (e == 23) chk("por_e23", {1'b0, rst_on}, 4'b0001);
            if (e == 24) chk("por_e24", {1'b0, rst_on}, 4'b0011);
            if (e == 31) chk("por_e31_busy", {3'b0, busy}, 4'h1);
            if (e == 32) chk("por_e32", {1'b0, rst_on}, 4'b0111);
            if (e == 32) chk("por_e32_busy", {3'b0, busy}, 4'h0);
        end

        // Software reset in RUN; finish exactly on RUN entry
        sw = 1'b1;
        cycle();
        chk("sw_rst_on", {1'b0, rst_on}, 4'b0000);
        chk("sw_cause", {2'b0, cause}, 4'h1);
        sw = 1'b0;
        for (int e = 1; e <= RUN_AT; e++) begin
            cycle();
            if (e == 16) chk("sw_e16", {1'b0, rst_on}, 4'b0001);
            if (e == 24) chk("sw_e24", {1'b0, rst_on}, 4'b0011);
            if (e == 32) chk("sw_e32", {1'b0, rst_on}, 4'b0111);
        end

        // Watchdog expiry, timeout 100, no kicks
        en = 1'b1;
        to = 16'd100;
        for (int e = 1; e <= 101; e++) begin
            cycle();
            if (e == 99)  chk("wdt_e99_bite", {3'b0, bite}, 4'h0);
            if (e == 100) chk("wdt_e100_bite", {3'b0, bite}, 4'h1);
            if (e == 100) chk("wdt_e100_cause", {2'b0, cause}, 4'h2);
            if (e == 100) chk("wdt_e100_rst_on", {1'b0, rst_on}, 4'b0000);
            if (e == 101) chk("wdt_e101_bite", {3'b0, bite}, 4'h0);
        end
        en = 1'b0;
        run(RUN_AT);

        // Kicks every 50 cycles for 1000 cycles
        en = 1'b1;
        for (int e = 1; e <= 1000; e++) begin
            kick = (e % 50 == 0);
            cycle();
        end
        kick = 1'b0;
        chk("kick_busy", {3'b0, busy}, 4'h0);
        chk("kick_cause", {2'b0, cause}, 4'h2);
        // Kick exactly on the expiry cycle
        run(99);
        kick = 1'b1;
        cycle();
        kick = 1'b0;
        chk("kick_exp_bite", {3'b0, bite}, 4'h0);
        chk("kick_exp_busy", {3'b0, busy}, 4'h0);
        run(5);

        // Lowering the timeout below the running count expires next edge
        run(50);
        to = 16'd20;
        cycle();
        chk("to_shrink_bite", {3'b0, bite}, 4'h1);
        chk("to_shrink_cause", {2'b0, cause}, 4'h2);
        en = 1'b0;
        to = 16'd100;
        run(RUN_AT);

        // Request in the middle of the release sequence
        sw = 1'b1;
        cycle();
        sw = 1'b0;
        run(20);
        chk("mid_e20", {1'b0, rst_on}, 4'b0001);
        sw = 1'b1;
        cycle();
        sw = 1'b0;
        chk("mid_req", {1'b0, rst_on}, 4'b0000);
        for (int e = 1; e <= RUN_AT; e++) begin
            cycle();
            if (e == 15) chk("mid_e15", {1'b0, rst_on}, 4'b0000);
            if (e == 16) chk("mid_e16", {1'b0, rst_on}, 4'b0001);
        end

        // Software request colliding with watchdog expiry
        en = 1'b1;
        to = 16'd10;
        run(9);
        sw = 1'b1;
        cycle();
        sw = 1'b0;
        chk("coll_cause", {2'b0, cause}, 4'h1);
        chk("coll_bite", {3'b0, bite}, 4'h0);
        en = 1'b0;
        cycle();
        chk("coll_bite_next", {3'b0, bite}, 4'h0);
        run(RUN_AT);

        // Timeout 0 disables the watchdog
        en = 1'b1;
        to = 16'd0;
        run(200);
        chk("to0_busy", {3'b0, busy}, 4'h0);
        en = 1'b0;

        // rst_i wins over a simultaneous software request
        rst = 1'b1;
        sw = 1'b1;
        cycle();
        chk("rst_prio_cause", {2'b0, cause}, 4'h0);
        chk("rst_prio_busy", {3'b0, busy}, 4'h1);
        sw = 1'b0;
        rst = 1'b0;
        run(RUN_AT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
